// File: rtl/entity_pkg.sv
// Shared types for the entity box scanner: box record, scan FSM states and defaults.
package entity_pkg;

    localparam int N_ENT_DEF   = 4;
    localparam int COORD_W_DEF = 8;
    // Pixel coordinate width; table coordinates are zero-extended to this.
    localparam int PIX_W       = 10;

    typedef struct packed {
        logic [PIX_W-1:0] tlx;
        logic [PIX_W-1:0] tly;
        logic [PIX_W-1:0] brx;
        logic [PIX_W-1:0] bry;
        logic             valid;
    } box_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // A box is usable only when its corners are in order on both axes.
    function automatic logic box_ordered(
        input logic [PIX_W-1:0] tlx,
        input logic [PIX_W-1:0] tly,
        input logic [PIX_W-1:0] brx,
        input logic [PIX_W-1:0] bry
    );
        return (tlx <= brx) && (tly <= bry);
    endfunction

endpackage

// File: rtl/entity_box_cmp.sv
// Combinational point-in-box test for one committed entity box (inclusive bounds).
module entity_box_cmp
    import entity_pkg::*;
(
    input  box_t             box_i,
    input  logic [PIX_W-1:0] draw_x_i,
    input  logic [PIX_W-1:0] draw_y_i,
    output logic             inside_o
);

    always_comb begin
        inside_o = box_i.valid
                && (draw_x_i >= box_i.tlx) && (draw_x_i <= box_i.brx)
                && (draw_y_i >= box_i.tly) && (draw_y_i <= box_i.bry);
    end

endmodule

// File: rtl/entity_box_scanner.sv
// Per-frame entity box scanner with shadow/active buffers and a registered pixel hit test.
// Optional request timeout is enabled by defining ENTITY_SCAN_TIMEOUT_EN.
module entity_box_scanner
    import entity_pkg::*;
#(
    parameter int N_ENT   = N_ENT_DEF,
    parameter int COORD_W = COORD_W_DEF,
`ifdef ENTITY_SCAN_TIMEOUT_EN
    parameter int TIMEOUT = 16,
`endif
    localparam int ID_W   = (N_ENT > 1) ? $clog2(N_ENT) : 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    output logic               req_valid,
    output logic [9:0]         req_entity,
    input  logic               rsp_valid,
    input  logic [COORD_W-1:0] TLX,
    input  logic [COORD_W-1:0] TLY,
    input  logic [COORD_W-1:0] BRX,
    input  logic [COORD_W-1:0] BRY,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    output logic               hit,
    output logic [ID_W-1:0]    hit_id,
    output logic               scan_busy,
    output logic               overrun,
    output scan_state_t        state_dbg
);

    // Handshake: req_valid/req_entity are held until a cycle with rsp_valid=1
    // (or a timeout); that cycle consumes the response and the index advances.
    // rsp_valid outside SCAN is ignored.

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_ENT - 1);

    scan_state_t     state_q, state_d;
    logic [ID_W-1:0] idx_q, idx_d;
    box_t            shadow_q [N_ENT];
    box_t            shadow_d [N_ENT];
    box_t            active_q [N_ENT];
    box_t            active_d [N_ENT];
    logic            overrun_q, overrun_d;
    logic            hit_q, hit_d;
    logic [ID_W-1:0] hit_id_q, hit_id_d;

    box_t            rsp_box;
    logic            advance;
    logic            timeout_c;
    logic [N_ENT-1:0] inside_c;

    always_comb begin
        rsp_box.tlx   = PIX_W'(TLX);
        rsp_box.tly   = PIX_W'(TLY);
        rsp_box.brx   = PIX_W'(BRX);
        rsp_box.bry   = PIX_W'(BRY);
        rsp_box.valid = box_ordered(PIX_W'(TLX), PIX_W'(TLY), PIX_W'(BRX), PIX_W'(BRY));
    end

`ifdef ENTITY_SCAN_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;

    always_comb begin
        timeout_c = (state_q == SCAN) && !rsp_valid && (wait_q == WAIT_W'(TIMEOUT - 1));
        wait_d    = wait_q;
        if ((state_q != SCAN) || advance) begin
            wait_d = '0;
        end else if (!rsp_valid) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    always_comb timeout_c = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        overrun_d = overrun_q;
        advance   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Nothing has been scanned yet, so there is nothing to commit.
                if (frame_start) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (frame_start) begin
                    overrun_d = 1'b1;
                end
                if (rsp_valid) begin
                    shadow_d[idx_q] = rsp_box;
                    advance         = 1'b1;
                end else if (timeout_c) begin
                    shadow_d[idx_q].valid = 1'b0;
                    advance               = 1'b1;
                end
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ID_W'(1);
                    end
                end
            end
            DONE: begin
                if (frame_start) begin
                    active_d = shadow_q;
                    state_d  = SCAN;
                    idx_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    for (genvar g = 0; g < N_ENT; g++) begin : g_cmp
        entity_box_cmp u_cmp (
            .box_i    (active_q[g]),
            .draw_x_i (DrawX),
            .draw_y_i (DrawY),
            .inside_o (inside_c[g])
        );
    end

    // Walk from the top down so the lowest hit index is the one left standing.
    always_comb begin
        hit_d    = |inside_c;
        hit_id_d = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (inside_c[i]) begin
                hit_id_d = ID_W'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            hit_q     <= 1'b0;
            hit_id_q  <= '0;
            for (int i = 0; i < N_ENT; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            hit_q     <= hit_d;
            hit_id_q  <= hit_id_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    assign req_valid  = (state_q == SCAN);
    assign req_entity = 10'(idx_q);
    assign scan_busy  = (state_q == SCAN);
    assign hit        = hit_q;
    assign hit_id     = hit_id_q;
    assign overrun    = overrun_q;
    assign state_dbg  = state_q;

endmodule
